qrd_in_skew: RTL and testbench

- Upstream feeder for the 4x4 complex QRD systolic core.
- Accepts matrix H as a serial stream of 16 complex samples in row-major order over a valid/ready handshake, and stores them in a local 4x4 buffer.
- Once the buffer is full, drives the core's four skewed row inputs:
  - row k carries H[k][0..3] followed by identity row k (augmented [H | I]);
  - each row is delayed k beats relative to row 1;
  - row_in_1_f..row_in_3_f flag pulses are generated alongside.
- Advances one beat only when the core asserts in_ready.

---
 rtl/qrd_pkg.sv | 31 +++
 rtl/qrd_skew_lane.sv | 44 ++++
 rtl/qrd_in_skew.sv | 151 +++++++++++++++
 tb/tb_qrd_in_skew.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qrd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qrd_pkg
// Description : Shared constants and types for the QRD input skew feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package qrd_pkg;

    localparam int W          = 14;
    localparam int FRAC       = 10;
    localparam int N          = 4;
    localparam logic [W-1:0] ONE = W'(1 << FRAC);

    // H columns, identity columns, then N-1 beats to drain the skew.
    localparam int FEED_BEATS = 2*N + N - 1;

    localparam int F1_BEAT = 0;
    localparam int F2_BEAT = 2;
    localparam int F3_BEAT = 4;

    typedef logic [0:0] state_t;
    localparam state_t LOAD = 1'b0;
    localparam state_t FEED = 1'b1;

    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
    } cplx_t;

endpackage
`default_nettype wire

// File: rtl/qrd_skew_lane.sv
`default_nettype none
// ============================================================================
// Module      : qrd_skew_lane
// Description : Selects stored sample, identity value or zero for one row.
// Revision    : 1.0 - initial release
// ============================================================================
module qrd_skew_lane #(
    parameter int LANE = 0,
    parameter int W    = 14,
    parameter int FRAC = 10
) (
    input  logic [3:0]     beat,
    input  logic [4*W-1:0] row_r,
    input  logic [4*W-1:0] row_i,
    output logic [W-1:0]   data_r,
    output logic [W-1:0]   data_i
);
    import qrd_pkg::*;

    localparam logic [3:0]   C_LANE = 4'(LANE);
    localparam logic [W-1:0] C_ONE  = W'(1) << FRAC;

    logic       w_ge;
    logic [3:0] w_j;
    logic [1:0] w_sel;

    // w_j is only meaningful when the beat has reached this lane's skew.
    assign w_ge  = (beat >= C_LANE);
    assign w_j   = beat - C_LANE;
    assign w_sel = w_j[1:0];

    always_comb begin
        data_r = '0;
        data_i = '0;
        if (w_ge && (w_j < 4'd4)) begin
            data_r = row_r[w_sel*W +: W];
            data_i = row_i[w_sel*W +: W];
        end else if (w_ge && (w_j < 4'd8) && (w_sel == C_LANE[1:0])) begin
            data_r = C_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/qrd_in_skew.sv
`default_nettype none
// ============================================================================
// Module      : qrd_in_skew
// Description : Buffers a 4x4 complex matrix and feeds [H | I] skewed rows.
// Revision    : 1.0 - initial release
// ============================================================================
module qrd_in_skew #(
    parameter int W    = qrd_pkg::W,
    parameter int FRAC = qrd_pkg::FRAC,
    parameter int N    = qrd_pkg::N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_r,
    input  logic [W-1:0] s_i,
    input  logic         qrd_in_ready,
    output logic [W-1:0] row_in_1_r,
    output logic [W-1:0] row_in_1_i,
    output logic [W-1:0] row_in_2_r,
    output logic [W-1:0] row_in_2_i,
    output logic [W-1:0] row_in_3_r,
    output logic [W-1:0] row_in_3_i,
    output logic [W-1:0] row_in_4_r,
    output logic [W-1:0] row_in_4_i,
    output logic         row_in_1_f,
    output logic         row_in_2_f,
    output logic         row_in_3_f,
    output logic         busy,
    output logic         done
);
    import qrd_pkg::*;

    localparam logic [3:0] C_LAST_BEAT = 4'(FEED_BEATS - 1);

    generate
        if (N != 4) begin : g_bad_n
            $error("qrd_in_skew supports only N == 4");
        end
    endgenerate

    state_t       r_state;
    logic [3:0]   r_wr_cnt;
    logic [3:0]   r_beat;
    logic [W-1:0] r_buf_r [16];
    logic [W-1:0] r_buf_i [16];
    logic [W-1:0] r_row_r [4];
    logic [W-1:0] r_row_i [4];
    logic [2:0]   r_flag;
    logic         r_done;

    logic         w_accept;
    logic [3:0]   w_nxt_beat;
    logic [2:0]   w_nxt_flag;
    logic [W-1:0] w_lane_r [4];
    logic [W-1:0] w_lane_i [4];

    assign w_accept   = s_valid && (r_state == LOAD);
    // Lanes always evaluate the beat that will be presented after the next edge.
    assign w_nxt_beat = (r_state == LOAD) ? 4'd0 : (r_beat + 4'd1);
    assign w_nxt_flag = {w_nxt_beat == 4'(F3_BEAT),
                         w_nxt_beat == 4'(F2_BEAT),
                         w_nxt_beat == 4'(F1_BEAT)};

    for (genvar k = 0; k < 4; k++) begin : g_lane
        qrd_skew_lane #(
            .LANE (k),
            .W    (W),
            .FRAC (FRAC)
        ) u_lane (
            .beat   (w_nxt_beat),
            .row_r  ({r_buf_r[4*k+3], r_buf_r[4*k+2], r_buf_r[4*k+1], r_buf_r[4*k]}),
            .row_i  ({r_buf_i[4*k+3], r_buf_i[4*k+2], r_buf_i[4*k+1], r_buf_i[4*k]}),
            .data_r (w_lane_r[k]),
            .data_i (w_lane_i[k])
        );
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf_r[r_wr_cnt] <= s_r;
            r_buf_i[r_wr_cnt] <= s_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= LOAD;
            r_wr_cnt <= 4'd0;
            r_beat   <= 4'd0;
            r_flag   <= 3'b000;
            r_done   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_row_r[i] <= '0;
                r_row_i[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (r_state == LOAD) begin
                if (w_accept) begin
                    r_wr_cnt <= r_wr_cnt + 4'd1;
                    if (r_wr_cnt == 4'd15) begin
                        r_state <= FEED;
                        r_beat  <= 4'd0;
                        r_flag  <= w_nxt_flag;
                        for (int i = 0; i < 4; i++) begin
                            r_row_r[i] <= w_lane_r[i];
                            r_row_i[i] <= w_lane_i[i];
                        end
                    end
                end
            end else if (qrd_in_ready) begin
                if (r_beat == C_LAST_BEAT) begin
                    r_state <= LOAD;
                    r_beat  <= 4'd0;
                    r_flag  <= 3'b000;
                    r_done  <= 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        r_row_r[i] <= '0;
                        r_row_i[i] <= '0;
                    end
                end else begin
                    r_beat <= w_nxt_beat;
                    r_flag <= w_nxt_flag;
                    for (int i = 0; i < 4; i++) begin
                        r_row_r[i] <= w_lane_r[i];
                        r_row_i[i] <= w_lane_i[i];
                    end
                end
            end
        end
    end

    assign s_ready    = (r_state == LOAD);
    assign busy       = (r_state == FEED);
    assign done       = r_done;
    assign row_in_1_r = r_row_r[0];
    assign row_in_1_i = r_row_i[0];
    assign row_in_2_r = r_row_r[1];
    assign row_in_2_i = r_row_i[1];
    assign row_in_3_r = r_row_r[2];
    assign row_in_3_i = r_row_i[2];
    assign row_in_4_r = r_row_r[3];
    assign row_in_4_i = r_row_i[3];
    assign row_in_1_f = r_flag[0];
    assign row_in_2_f = r_flag[1];
    assign row_in_3_f = r_flag[2];

endmodule
`default_nettype wire

// File: tb/tb_qrd_in_skew.sv
`default_nettype none
// ============================================================================
// Module      : tb_qrd_in_skew
// Description : Directed self-checking bench for qrd_in_skew.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qrd_in_skew;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [13:0] s_r;
    logic [13:0] s_i;
    logic        qrd_in_ready;
    logic [13:0] row_in_1_r, row_in_1_i, row_in_2_r, row_in_2_i;
    logic [13:0] row_in_3_r, row_in_3_i, row_in_4_r, row_in_4_i;
    logic        row_in_1_f, row_in_2_f, row_in_3_f;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [13:0] h_r [16];
    logic [13:0] h_i [16];
    logic [13:0] obs_r [4];
    logic [13:0] obs_i [4];

    qrd_in_skew dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_r          (s_r),
        .s_i          (s_i),
        .qrd_in_ready (qrd_in_ready),
        .row_in_1_r   (row_in_1_r),
        .row_in_1_i   (row_in_1_i),
        .row_in_2_r   (row_in_2_r),
        .row_in_2_i   (row_in_2_i),
        .row_in_3_r   (row_in_3_r),
        .row_in_3_i   (row_in_3_i),
        .row_in_4_r   (row_in_4_r),
        .row_in_4_i   (row_in_4_i),
        .row_in_1_f   (row_in_1_f),
        .row_in_2_f   (row_in_2_f),
        .row_in_3_f   (row_in_3_f),
        .busy         (busy),
        .done         (done)
    );

    assign obs_r[0] = row_in_1_r;
    assign obs_i[0] = row_in_1_i;
    assign obs_r[1] = row_in_2_r;
    assign obs_i[1] = row_in_2_i;
    assign obs_r[2] = row_in_3_r;
    assign obs_i[2] = row_in_3_i;
    assign obs_r[3] = row_in_4_r;
    assign obs_i[3] = row_in_4_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected row k at beat l for the augmented [H | I] skewed feed.
    function automatic logic [13:0] exp_r(input int k, input int l);
        int j;
        j = l - k;
        if (j >= 0 && j < 4) return h_r[4*k+j];
        if (j >= 4 && j < 8 && (j - 4) == k) return 14'd1024;
        return 14'd0;
    endfunction

    function automatic logic [13:0] exp_i(input int k, input int l);
        int j;
        j = l - k;
        if (j >= 0 && j < 4) return h_i[4*k+j];
        return 14'd0;
    endfunction

    task automatic set_pattern(input int p);
        for (int idx = 0; idx < 16; idx++) begin
            case (p)
                0: begin h_r[idx] = 14'(4*idx + 1);  h_i[idx] = 14'(-(4*idx + 2)); end
                1: begin h_r[idx] = 14'(7*idx - 50); h_i[idx] = 14'(100 + 3*idx);  end
                default: begin
                    h_r[idx] = (idx % 2 == 0) ? 14'h2000 : 14'h1FFF;
                    h_i[idx] = (idx % 2 == 0) ? 14'h1FFF : 14'h2000;
                end
            endcase
        end
    endtask

    task automatic load_matrix(input string name, input bit toggle);
        for (int idx = 0; idx < 16; idx++) begin
            s_valid = 1'b1;
            s_r = h_r[idx];
            s_i = h_i[idx];
            @(posedge clk); #1;
            if (toggle && idx < 15 && (idx % 2 == 0)) begin
                s_valid = 1'b0;
                s_r = 14'h1555;
                s_i = 14'h0AAA;
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s load_end: busy=%b s_ready=%b required busy=1 s_ready=0", name, busy, s_ready);
        end
    endtask

    task automatic feed_matrix(input string name, input bit offer);
        qrd_in_ready = 1'b1;
        for (int l = 0; l < 11; l++) begin
            if (offer) begin
                s_valid = 1'b1;
                s_r = 14'h1234;
                s_i = 14'h0ABC;
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs_r[k] !== exp_r(k, l) || obs_i[k] !== exp_i(k, l)) begin
                    errors++;
                    $display("FAIL %s beat%0d row%0d: got %0d,%0d required %0d,%0d",
                             name, l, k + 1, obs_r[k], obs_i[k], exp_r(k, l), exp_i(k, l));
                end
            end
            checks++;
            if ({row_in_3_f, row_in_2_f, row_in_1_f} !== {l == 4, l == 2, l == 0}) begin
                errors++;
                $display("FAIL %s flags beat%0d: got %b required %b", name, l,
                         {row_in_3_f, row_in_2_f, row_in_1_f}, {l == 4, l == 2, l == 0});
            end
            checks++;
            if (busy !== 1'b1 || s_ready !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s status beat%0d: busy=%b s_ready=%b done=%b required 1 0 0",
                         name, l, busy, s_ready, done);
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1 ||
            row_in_1_r !== 14'd0 || row_in_4_r !== 14'd0 || row_in_1_f !== 1'b0) begin
            errors++;
            $display("FAIL %s end: done=%b busy=%b s_ready=%b r1=%0d r4=%0d f1=%b required 1 0 1 0 0 0",
                     name, done, busy, s_ready, row_in_1_r, row_in_4_r, row_in_1_f);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: done=%b required 0", name, done);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        s_valid = 1'b0;
        s_r = '0;
        s_i = '0;
        qrd_in_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: s_ready=%b busy=%b done=%b required 1 0 0", s_ready, busy, done);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_r[k] !== 14'd0 || obs_i[k] !== 14'd0) begin
                errors++;
                $display("FAIL reset_row%0d: got %0d,%0d required 0,0", k + 1, obs_r[k], obs_i[k]);
            end
        end
        checks++;
        if ({row_in_3_f, row_in_2_f, row_in_1_f} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000", {row_in_3_f, row_in_2_f, row_in_1_f});
        end
        rst = 1'b0;
    endtask

    task automatic test_load_feed;
        set_pattern(0);
        qrd_in_ready = 1'b1;
        load_matrix("basic", 1'b0);
        for (int l = 0; l < 11; l++) begin
            if (l == 0) begin
                checks++;
                if (row_in_1_r !== 14'd1 || row_in_1_i !== 14'h3FFE || row_in_1_f !== 1'b1 ||
                    row_in_2_r !== 14'd0 || row_in_3_r !== 14'd0 || row_in_4_r !== 14'd0) begin
                    errors++;
                    $display("FAIL beat0: r1=%0d,%0d f1=%b r2=%0d r3=%0d r4=%0d required 1,16382 1 0 0 0",
                             row_in_1_r, row_in_1_i, row_in_1_f, row_in_2_r, row_in_3_r, row_in_4_r);
                end
            end
            if (l == 3) begin
                checks++;
                if (row_in_4_r !== 14'd49 || row_in_4_i !== 14'(-50)) begin
                    errors++;
                    $display("FAIL beat3_row4: got %0d,%0d required 49,%0d", row_in_4_r, row_in_4_i, 14'(-50));
                end
            end
            if (l == 4) begin
                checks++;
                if (row_in_1_r !== 14'd1024 || row_in_1_i !== 14'd0) begin
                    errors++;
                    $display("FAIL beat4_row1: got %0d,%0d required 1024,0", row_in_1_r, row_in_1_i);
                end
            end
            if (l == 10) begin
                checks++;
                if (row_in_4_r !== 14'd1024 || row_in_4_i !== 14'd0) begin
                    errors++;
                    $display("FAIL beat10_row4: got %0d,%0d required 1024,0", row_in_4_r, row_in_4_i);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b required 1 0", done, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b required 0", done);
        end
    endtask

    task automatic test_flags;
        set_pattern(1);
        load_matrix("flags", 1'b0);
        feed_matrix("flags", 1'b0);
    endtask

    task automatic test_backpressure;
        int cyc;
        set_pattern(0);
        qrd_in_ready = 1'b1;
        load_matrix("bp", 1'b0);
        cyc = 0;
        for (int l = 0; l < 6; l++) begin
            if (busy === 1'b1) cyc++;
            @(posedge clk); #1;
        end
        qrd_in_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            if (busy === 1'b1) cyc++;
            checks++;
            if (row_in_2_r !== 14'd1024 || row_in_2_i !== 14'd0 ||
                row_in_3_r !== 14'd0 || row_in_3_i !== 14'd0 ||
                row_in_4_r !== h_r[15] || row_in_4_i !== h_i[15] ||
                row_in_1_r !== 14'd0 || {row_in_3_f, row_in_2_f, row_in_1_f} !== 3'b000) begin
                errors++;
                $display("FAIL bp_hold%0d: r1=%0d r2=%0d,%0d r3=%0d,%0d r4=%0d,%0d required 0 1024,0 0,0 %0d,%0d",
                         s, row_in_1_r, row_in_2_r, row_in_2_i, row_in_3_r, row_in_3_i,
                         row_in_4_r, row_in_4_i, h_r[15], h_i[15]);
            end
            @(posedge clk); #1;
        end
        qrd_in_ready = 1'b1;
        for (int l = 6; l < 11; l++) begin
            if (busy === 1'b1) cyc++;
            checks++;
            if (row_in_4_r !== exp_r(3, l) || row_in_1_r !== exp_r(0, l)) begin
                errors++;
                $display("FAIL bp_resume beat%0d: r1=%0d r4=%0d required %0d %0d",
                         l, row_in_1_r, row_in_4_r, exp_r(0, l), exp_r(3, l));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (cyc != 16 || busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL bp_cycles: feed_cycles=%0d busy=%b done=%b required 16 0 1", cyc, busy, done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_handshake;
        set_pattern(1);
        load_matrix("toggle", 1'b1);
        feed_matrix("toggle", 1'b1);
        set_pattern(0);
        load_matrix("next", 1'b0);
        feed_matrix("next", 1'b0);
    endtask

    task automatic test_reset_mid_feed;
        set_pattern(1);
        qrd_in_ready = 1'b1;
        load_matrix("rstfeed", 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b1 || done !== 1'b0 ||
            row_in_1_r !== 14'd0 || row_in_2_r !== 14'd0 || row_in_3_r !== 14'd0 ||
            row_in_4_r !== 14'd0 || row_in_1_i !== 14'd0 || row_in_4_i !== 14'd0 ||
            {row_in_3_f, row_in_2_f, row_in_1_f} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset: busy=%b s_ready=%b done=%b r1=%0d r2=%0d r3=%0d r4=%0d required 0 1 0 0 0 0 0",
                     busy, s_ready, done, row_in_1_r, row_in_2_r, row_in_3_r, row_in_4_r);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_nodone: done=%b busy=%b required 0 0", done, busy);
        end
        set_pattern(0);
        load_matrix("after_rst", 1'b0);
        feed_matrix("after_rst", 1'b0);
    endtask

    task automatic test_extreme;
        set_pattern(2);
        load_matrix("extreme", 1'b0);
        checks++;
        if (row_in_1_r !== 14'h2000 || row_in_1_i !== 14'h1FFF) begin
            errors++;
            $display("FAIL extreme_beat0: got %h,%h required 2000,1fff", row_in_1_r, row_in_1_i);
        end
        feed_matrix("extreme", 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_feed();
        test_flags();
        test_backpressure();
        test_handshake();
        test_reset_mid_feed();
        test_extreme();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
